// File: rtl/pattern_chk_pkg.sv
// pattern_chk_pkg: shared definitions for the test-pattern FIFO checker.
// Word layout is two 64-bit lanes {flag, cnt}, hi lane in [127:64], lo lane
// carries cnt+1.
package pattern_chk_pkg;

    localparam int FLAG_W      = 8;
    localparam int CNT_W       = 56;
    localparam int LANE_W      = FLAG_W + CNT_W;
    localparam int WORD_W      = 2 * LANE_W;

    localparam int LO_CNT_LSB  = 0;
    localparam int LO_FLAG_LSB = CNT_W;
    localparam int HI_CNT_LSB  = LANE_W;
    localparam int HI_FLAG_LSB = LANE_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } chk_state_e;

    // Word the generator produces for a given flag and hi-lane count
    function automatic logic [WORD_W-1:0] build_expected(
        input logic [FLAG_W-1:0] flag,
        input logic [CNT_W-1:0]  cnt
    );
        logic [CNT_W-1:0] cnt_lo;
        cnt_lo = cnt + CNT_W'(1);
        return {flag, cnt, flag, cnt_lo};
    endfunction

endpackage

// File: rtl/pattern_rate_meter.sv
// pattern_rate_meter: free-running window counter; at the end of each window
// the number of valid words seen is shifted down and published as a rate.
// A word arriving on the boundary cycle is credited to the new window.
module pattern_rate_meter #(
    parameter int unsigned WINDOW = 200_000_000,
    parameter int          SHIFT  = 16,
    parameter int          RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              word_vld,
    output logic [RATE_W-1:0] rate
);

    localparam int CYC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WIN_W = $clog2(WINDOW) + 1;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              terminal;

    assign terminal = (cyc_q == CYC_W'(WINDOW - 1));
    assign rate     = rate_q;

    // Advance the window and publish the rate on the terminal cycle
    always_comb begin
        cyc_d  = cyc_q + CYC_W'(1);
        win_d  = win_q + WIN_W'(word_vld);
        rate_d = rate_q;
        if (terminal) begin
            cyc_d  = '0;
            win_d  = WIN_W'(word_vld);
            rate_d = RATE_W'(win_q >> SHIFT);
        end
    end

    // Window registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            win_q  <= '0;
            rate_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            win_q  <= win_d;
            rate_q <= rate_d;
        end
    end

endmodule

// File: rtl/fifo_pattern_checker.sv
// fifo_pattern_checker: drains the upstream test-pattern FIFO, locks onto the
// {flag, cnt, flag, cnt+1} counter sequence, checks every word and reports
// lock state, error/word counts and read throughput.
// Optional first-mismatch capture is built when PATTERN_CHK_FIRST_ERR_EN is defined.
//
// state | meaning
// IDLE  | checking disabled; no reads, exp held
// HUNT  | waiting for a well-formed word to seed exp
// LOCK  | every word compared against exp; resync on mismatch
module fifo_pattern_checker
    import pattern_chk_pkg::*;
#(
    parameter int          DATA_WIDTH    = 128,
    parameter int          CNT_WIDTH     = 56,
    parameter int          ERR_CNT_WIDTH = 16,
    parameter int          LOSS_THRESH   = 4,
    parameter int unsigned RATE_WINDOW   = 200_000_000,
    parameter int          RATE_SHIFT    = 16
) (
    input  logic                     log_clk,
    input  logic                     log_rst_n,
    input  logic                     chk_en,
    input  logic                     clr_stats,
    input  logic [FLAG_W-1:0]        channel_flag,
    output logic                     fifo_rdreq,
    input  logic [DATA_WIDTH-1:0]    fifo_q,
    input  logic                     fifo_empty,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [47:0]              word_cnt,
    output logic [15:0]              rate_mbps,
    output logic [DATA_WIDTH-1:0]    first_err_rx,
    output logic [DATA_WIDTH-1:0]    first_err_exp
);

    localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

    chk_state_e               state_q, state_d;
    logic                     chk_en_q, chk_en_d;
    logic                     q_vld_q, q_vld_d;
    logic                     cmp_vld_q, cmp_vld_d;
    logic [DATA_WIDTH-1:0]    q_r_q, q_r_d;
    logic [CNT_WIDTH-1:0]     exp_q, exp_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic [47:0]              word_q, word_d;
    logic [CONSEC_W-1:0]      consec_q, consec_d;

    logic [FLAG_W-1:0]        hi_flag, lo_flag;
    logic [CNT_WIDTH-1:0]     hi_cnt, lo_cnt;
    logic [DATA_WIDTH-1:0]    exp_word;
    logic                     hunt_ok, word_match;

    assign hi_flag    = q_r_q[HI_FLAG_LSB +: FLAG_W];
    assign hi_cnt     = q_r_q[HI_CNT_LSB  +: CNT_WIDTH];
    assign lo_flag    = q_r_q[LO_FLAG_LSB +: FLAG_W];
    assign lo_cnt     = q_r_q[LO_CNT_LSB  +: CNT_WIDTH];
    assign exp_word   = build_expected(channel_flag, exp_q);
    assign word_match = (q_r_q == exp_word);
    assign hunt_ok    = (hi_flag == channel_flag) && (lo_flag == channel_flag) &&
                        (lo_cnt == hi_cnt + CNT_WIDTH'(1)) && !hi_cnt[0];

    // Never read on empty: gated by live fifo_empty
    assign fifo_rdreq = chk_en_q & ~fifo_empty & (state_q != IDLE);

    assign locked   = (state_q == LOCK);
    assign err_cnt  = err_q;
    assign word_cnt = word_q;

    // Enable register and read-data pipeline (data valid one cycle after the request)
    always_comb begin
        chk_en_d  = chk_en;
        q_vld_d   = fifo_rdreq;
        cmp_vld_d = q_vld_q;
        q_r_d     = q_vld_q ? fifo_q : q_r_q;
    end

    // Pipeline registers; an in-flight read is dropped on reset
    always_ff @(posedge log_clk) begin
        if (!log_rst_n) begin
            chk_en_q  <= 1'b0;
            q_vld_q   <= 1'b0;
            cmp_vld_q <= 1'b0;
            q_r_q     <= '0;
        end else begin
            chk_en_q  <= chk_en_d;
            q_vld_q   <= q_vld_d;
            cmp_vld_q <= cmp_vld_d;
            q_r_q     <= q_r_d;
        end
    end

    // Next-state, expected-count tracking and statistics
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        err_d    = err_q;
        word_d   = word_q;
        consec_d = consec_q;
        if (!chk_en_q) begin
            state_d  = IDLE;
            consec_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    consec_d = '0;
                    state_d  = HUNT;
                end
                HUNT: begin
                    if (cmp_vld_q && hunt_ok) begin
                        exp_d    = hi_cnt + CNT_WIDTH'(2);
                        consec_d = '0;
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
                    if (cmp_vld_q) begin
                        word_d = word_q + 48'd1;
                        if (word_match) begin
                            exp_d    = exp_q + CNT_WIDTH'(2);
                            consec_d = '0;
                        end else begin
                            err_d    = (err_q == '1) ? err_q : err_q + ERR_CNT_WIDTH'(1);
                            exp_d    = hi_cnt + CNT_WIDTH'(2);
                            consec_d = consec_q + CONSEC_W'(1);
                            if (consec_d == CONSEC_W'(LOSS_THRESH)) begin
                                consec_d = '0;
                                state_d  = HUNT;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A clear coincident with a mismatch wins
        if (clr_stats) begin
            err_d  = '0;
            word_d = '0;
        end
    end

    // State and statistics registers
    always_ff @(posedge log_clk) begin
        if (!log_rst_n) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            err_q    <= '0;
            word_q   <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            word_q   <= word_d;
            consec_q <= consec_d;
        end
    end

    pattern_rate_meter #(
        .WINDOW (RATE_WINDOW),
        .SHIFT  (RATE_SHIFT),
        .RATE_W (16)
    ) u_rate (
        .clk      (log_clk),
        .rst_n    (log_rst_n),
        .word_vld (q_vld_q),
        .rate     (rate_mbps)
    );

`ifdef PATTERN_CHK_FIRST_ERR_EN
    logic                  lock_mismatch;
    logic                  fe_armed_q, fe_armed_d;
    logic [DATA_WIDTH-1:0] fe_rx_q, fe_rx_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;

    assign lock_mismatch = chk_en_q && (state_q == LOCK) && cmp_vld_q && !word_match;
    assign first_err_rx  = fe_rx_q;
    assign first_err_exp = fe_exp_q;

    // Capture the first LOCK mismatch; clear re-arms
    always_comb begin
        fe_armed_d = fe_armed_q;
        fe_rx_d    = fe_rx_q;
        fe_exp_d   = fe_exp_q;
        if (clr_stats) begin
            fe_armed_d = 1'b0;
            fe_rx_d    = '0;
            fe_exp_d   = '0;
        end else if (lock_mismatch && !fe_armed_q) begin
            fe_armed_d = 1'b1;
            fe_rx_d    = q_r_q;
            fe_exp_d   = exp_word;
        end
    end

    // First-error capture registers
    always_ff @(posedge log_clk) begin
        if (!log_rst_n) begin
            fe_armed_q <= 1'b0;
            fe_rx_q    <= '0;
            fe_exp_q   <= '0;
        end else begin
            fe_armed_q <= fe_armed_d;
            fe_rx_q    <= fe_rx_d;
            fe_exp_q   <= fe_exp_d;
        end
    end
`else
    assign first_err_rx  = '0;
    assign first_err_exp = '0;
`endif

endmodule

// File: tb/tb_fifo_pattern_checker.sv
// tb_fifo_pattern_checker: emulates the upstream FIFO from a word queue and
// checks the checker against a transaction-level model of the pattern rules.
module tb_fifo_pattern_checker;

    localparam int DW = 128;
    localparam int LT = 4;
    localparam int RW = 1000;
    localparam int RS = 0;

    logic          log_clk = 1'b0;
    logic          log_rst_n = 1'b0;
    logic          chk_en = 1'b0;
    logic          clr_stats = 1'b0;
    logic [7:0]    channel_flag = 8'h5A;
    logic          fifo_rdreq;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_empty = 1'b1;
    logic          locked;
    logic [15:0]   err_cnt;
    logic [47:0]   word_cnt;
    logic [15:0]   rate_mbps;
    logic [DW-1:0] first_err_rx;
    logic [DW-1:0] first_err_exp;

    fifo_pattern_checker #(
        .LOSS_THRESH (LT),
        .RATE_WINDOW (RW),
        .RATE_SHIFT  (RS)
    ) dut (
        .log_clk       (log_clk),
        .log_rst_n     (log_rst_n),
        .chk_en        (chk_en),
        .clr_stats     (clr_stats),
        .channel_flag  (channel_flag),
        .fifo_rdreq    (fifo_rdreq),
        .fifo_q        (fifo_q),
        .fifo_empty    (fifo_empty),
        .locked        (locked),
        .err_cnt       (err_cnt),
        .word_cnt      (word_cnt),
        .rate_mbps     (rate_mbps),
        .first_err_rx  (first_err_rx),
        .first_err_exp (first_err_exp)
    );

    always #5 log_clk = ~log_clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] stim_q[$];

    // words popped one and two edges ago (data reaches the comparison two edges after the pop)
    logic         p1_v = 1'b0, p2_v = 1'b0;
    logic [127:0] p1_w = '0,   p2_w = '0;

    // transaction-level model
    logic         m_en_r = 1'b0, m_active = 1'b0, m_locked = 1'b0;
    logic [55:0]  m_exp = '0;
    int           m_consec = 0;
    logic [15:0]  m_err = '0;
    logic [47:0]  m_words = '0;
    logic [15:0]  m_rate = '0;
    int           m_n = 0;
    int           m_win = 0;
    logic         m_fe_armed = 1'b0;
    logic [127:0] m_fe_rx = '0, m_fe_exp = '0;
    logic         clr_arm = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [127:0] pat(input logic [7:0] f, input logic [55:0] c, input logic [55:0] lo);
        return {f, c, f, lo};
    endfunction

    task automatic apply_word(input logic [127:0] w);
        logic [7:0]   hf, lf;
        logic [55:0]  hc, lc, hc1;
        logic [127:0] ew;
        hf  = w[127:120];
        hc  = w[119:64];
        lf  = w[63:56];
        lc  = w[55:0];
        hc1 = hc + 56'd1;
        if (!m_locked) begin
            if (hf == channel_flag && lf == channel_flag && lc == hc1 && !hc[0]) begin
                m_locked = 1'b1;
                m_exp    = hc + 56'd2;
                m_consec = 0;
            end
        end else begin
            ew      = pat(channel_flag, m_exp, m_exp + 56'd1);
            m_words = m_words + 48'd1;
            if (w == ew) begin
                m_exp    = m_exp + 56'd2;
                m_consec = 0;
            end else begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                if (!m_fe_armed) begin
                    m_fe_armed = 1'b1;
                    m_fe_rx    = w;
                    m_fe_exp   = ew;
                end
                m_exp    = hc + 56'd2;
                m_consec = m_consec + 1;
                if (m_consec == LT) begin
                    m_locked = 1'b0;
                    m_consec = 0;
                end
            end
        end
    endtask

    // model update for one clock edge, using the inputs the DUT saw at that edge
    task automatic model_edge(input logic popped, input logic [127:0] pw);
        logic vld_now;
        vld_now = p1_v;
        if (!log_rst_n) begin
            m_en_r = 0; m_active = 0; m_locked = 0; m_exp = '0; m_consec = 0;
            m_err = '0; m_words = '0; m_rate = '0; m_n = 0; m_win = 0;
            m_fe_armed = 0; m_fe_rx = '0; m_fe_exp = '0;
            p1_v = 0; p2_v = 0;
            return;
        end
        if ((m_n % RW) == RW - 1) begin
            m_rate = 16'(m_win >> RS);
            m_win  = int'(vld_now);
        end else begin
            m_win = m_win + int'(vld_now);
        end
        m_n++;
        if (!m_en_r) begin
            m_active = 0; m_locked = 0; m_consec = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (p2_v) begin
            apply_word(p2_w);
        end
        if (clr_stats) begin
            m_err = '0; m_words = '0; m_fe_armed = 0; m_fe_rx = '0; m_fe_exp = '0;
        end
        m_en_r = chk_en;
        p2_v = p1_v; p2_w = p1_w;
        p1_v = popped; p1_w = pw;
    endtask

    task automatic compare_outputs(input logic rd);
        check("locked", locked, m_locked);
        check("err_cnt", err_cnt, m_err);
        check("word_cnt", word_cnt, m_words);
        check("rate_mbps", rate_mbps, m_rate);
`ifdef PATTERN_CHK_FIRST_ERR_EN
        check("first_err_rx", first_err_rx, m_fe_rx);
        check("first_err_exp", first_err_exp, m_fe_exp);
`else
        check("first_err_rx_tied", first_err_rx, '0);
        check("first_err_exp_tied", first_err_exp, '0);
`endif
        if (rd) check("rdreq_on_empty", fifo_empty, 1'b0);
    endtask

    task automatic cycle();
        logic         rd, popped;
        logic [127:0] pw;
        @(negedge log_clk);
        rd = fifo_rdreq;
        compare_outputs(rd);
        @(posedge log_clk);
        #1;
        popped = 1'b0;
        pw     = '0;
        if (rd && log_rst_n && stim_q.size() > 0) begin
            pw     = stim_q.pop_front();
            popped = 1'b1;
            fifo_q = pw;
        end
        model_edge(popped, pw);
        fifo_empty = (stim_q.size() == 0);
        clr_stats  = 1'b0;
        if (clr_arm && p2_v) begin
            clr_stats = 1'b1;
            clr_arm   = 1'b0;
        end
    endtask

    task automatic push_word(input logic [127:0] w);
        stim_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic push_stream(input logic [55:0] start, input int n);
        logic [55:0] c;
        c = start;
        for (int i = 0; i < n; i++) begin
            push_word(pat(8'h5A, c, c + 56'd1));
            c = c + 56'd2;
        end
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while (stim_q.size() > 0 && guard < 5000) begin
            cycle();
            guard++;
        end
        check("drain_left", 128'(stim_q.size()), '0);
        repeat (extra) cycle();
    endtask

    initial begin
        @(posedge log_clk);
        #1;
        model_edge(1'b0, '0);
        repeat (3) cycle();
        check("rst_locked", locked, 1'b0);
        check("rst_rdreq", fifo_rdreq, 1'b0);
        check("rst_err", err_cnt, '0);
        check("rst_words", word_cnt, '0);
        check("rst_rate", rate_mbps, '0);

        // 10 words from cnt=0: first locks, 9 counted
        push_stream(56'd0, 10);
        log_rst_n = 1'b1;
        chk_en    = 1'b1;
        drain(4);
        check("t1_locked", locked, 1'b1);
        check("t1_words", word_cnt, 48'd9);
        check("t1_err", err_cnt, 16'd0);
        check("t1_model_exp", 128'(m_exp), 128'd20);

        // disable drops lock; relock on a stream that wraps the counter
        chk_en = 1'b0;
        repeat (3) cycle();
        check("t2_idle_unlocked", locked, 1'b0);
        chk_en = 1'b1;
        push_stream(56'hFF_FFFF_FFFF_FFFC, 6);
        drain(4);
        check("t2_locked", locked, 1'b1);
        check("t2_words", word_cnt, 48'd14);
        check("t2_err", err_cnt, 16'd0);
        check("t2_model_exp", 128'(m_exp), 128'd8);

        // one word with lo.cnt corrupted
        push_stream(56'd8, 1);
        push_word(pat(8'h5A, 56'd10, 56'd13));
        push_stream(56'd12, 2);
        drain(4);
        check("t3_err", err_cnt, 16'd1);
        check("t3_locked", locked, 1'b1);
        check("t3_words", word_cnt, 48'd18);

        // jump 100 -> 500, resync to 502
        push_stream(56'd16, 43);
        push_stream(56'd500, 3);
        drain(4);
        check("t4_err", err_cnt, 16'd2);
        check("t4_words", word_cnt, 48'd64);
        check("t4_model_exp", 128'(m_exp), 128'd506);

        // five garbage words: lock lost after the fourth, fifth rejected in HUNT
        repeat (5) push_word('0);
        drain(4);
        check("t5_unlocked", locked, 1'b0);
        check("t5_err", err_cnt, 16'd6);
        check("t5_words", word_cnt, 48'd68);
        push_stream(56'd1000, 3);
        drain(4);
        check("t5_relocked", locked, 1'b1);
        check("t5_words2", word_cnt, 48'd70);

        // clear coincident with a mismatch wins
        push_word(pat(8'h5A, 56'd1006, 56'd1009 + 56'd3));
        clr_arm = 1'b1;
        drain(4);
        check("t6_err_clr", err_cnt, 16'd0);
        check("t6_words_clr", word_cnt, 48'd0);
        check("t6_locked", locked, 1'b1);
        push_word(pat(8'h5A, 56'd1008, 56'd1012));
        drain(4);
        check("t6_err", err_cnt, 16'd1);
`ifdef PATTERN_CHK_FIRST_ERR_EN
        check("t6_fe_rx", first_err_rx, pat(8'h5A, 56'd1008, 56'd1012));
        check("t6_fe_exp", first_err_exp, pat(8'h5A, 56'd1008, 56'd1009));
`else
        check("t6_fe_rx_tied", first_err_rx, '0);
`endif

        // back-to-back words over full windows
        push_stream(56'd1010, 2100);
        while (stim_q.size() > 50) cycle();
        check("t7_rate", rate_mbps, 16'd1000);
        drain(4);
        check("t7_words", word_cnt, 48'd2101);
        check("t7_err", err_cnt, 16'd1);
        check("t7_locked", locked, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
